// File: rtl/f_pc_fetch.sv
// Fetch-stage PC register and single-outstanding instruction-memory request sequencer.
// Delivers one instruction (or an address-error marker) per PC to the F/D register.
module f_pc_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] ADDR_LO  = 32'h0000_3000,
    parameter logic [31:0] ADDR_HI  = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    output logic [31:0] F_pc,
    output logic [31:0] F_instr,
    output logic        F_valid,
    output logic        F_excAdEL,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] buf_instr;
    logic        buf_exc;
    logic        bad;
    logic        advance;
    logic        capture;

    assign bad = (F_pc[1:0] != 2'b00) || (F_pc < ADDR_LO) || (F_pc > ADDR_HI);

    assign advance = F_valid & ~stall;
    assign capture = F_valid & stall & (state == S_FETCH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (capture) state_nxt = S_HOLD;
            S_HOLD:  if (!stall)  state_nxt = S_FETCH;
            default:              state_nxt = S_FETCH;
        endcase
    end

    // Outputs are gated by reset so the request drops the instant reset asserts.
    always_comb begin
        F_instr   = '0;
        F_valid   = 1'b0;
        F_excAdEL = 1'b0;
        imem_req  = 1'b0;
        imem_addr = F_pc;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    if (bad) begin
                        F_valid   = 1'b1;
                        F_excAdEL = 1'b1;
                    end else begin
                        imem_req = 1'b1;
                        if (imem_ack) begin
                            F_valid = 1'b1;
                            F_instr = imem_rdata;
                        end
                    end
                end
                S_HOLD: begin
                    F_valid   = 1'b1;
                    F_instr   = buf_instr;
                    F_excAdEL = buf_exc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            F_pc      <= PC_RESET;
            buf_instr <= '0;
            buf_exc   <= 1'b0;
        end else if (advance) begin
            F_pc      <= npc;
            buf_instr <= '0;
            buf_exc   <= 1'b0;
        end else if (capture) begin
            buf_instr <= F_instr;
            buf_exc   <= F_excAdEL;
        end
    end

endmodule

// File: tb/tb_f_pc_fetch.sv
// Scoreboard bench for f_pc_fetch: stimulus pushes expected deliveries, a negedge monitor pops them.
module tb_f_pc_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic        F_valid;
    logic        F_excAdEL;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } deliv_t;

    deliv_t exp_q[$];

    f_pc_fetch #(
        .PC_RESET(32'h0000_3000),
        .ADDR_LO (32'h0000_3000),
        .ADDR_HI (32'h0000_6ffc)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .npc       (npc),
        .stall     (stall),
        .F_pc      (F_pc),
        .F_instr   (F_instr),
        .F_valid   (F_valid),
        .F_excAdEL (F_excAdEL),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every valid cycle must match the oldest expected delivery.
    always @(negedge clk) begin
        if (F_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got F_pc=%h F_instr=%h exc=%b expected no delivery at %0t",
                         F_pc, F_instr, F_excAdEL, $time);
            end else begin
                deliv_t e;
                e = exp_q.pop_front();
                check32("mon_pc",    F_pc,            e.pc);
                check32("mon_instr", F_instr,         e.instr);
                check32("mon_exc",   {31'd0, F_excAdEL}, {31'd0, e.exc});
            end
        end else begin
            check32("idle_instr_zero", F_instr, 32'h0);
        end
    end

    // One clock cycle: called at posedge+1, drives inputs, checks request at negedge+1,
    // returns at the next posedge+1.
    task automatic cyc(input logic ack, input logic [31:0] rd, input logic stl, input logic [31:0] n,
                       input logic exp_req, input logic [31:0] exp_addr,
                       input logic deliver, input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic e_exc);
        deliv_t d;
        imem_ack   = ack;
        imem_rdata = rd;
        stall      = stl;
        npc        = n;
        if (deliver) begin
            d.pc = e_pc; d.instr = e_instr; d.exc = e_exc;
            exp_q.push_back(d);
        end
        @(negedge clk); #1;
        check32("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check32("imem_addr", imem_addr, exp_addr);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; npc = '0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        @(negedge clk); #1;
        check32("rst_pc",    F_pc,                32'h0000_3000);
        check32("rst_req",   {31'd0, imem_req},   32'd0);
        check32("rst_valid", {31'd0, F_valid},    32'd0);
        check32("rst_exc",   {31'd0, F_excAdEL},  32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Zero-wait memory: one instruction per cycle.
        cyc(1, 32'h2401_3000, 0, 32'h3004, 1, 32'h3000, 1, 32'h3000, 32'h2401_3000, 0);
        cyc(1, 32'h2401_3004, 0, 32'h3008, 1, 32'h3004, 1, 32'h3004, 32'h2401_3004, 0);
        cyc(1, 32'h2401_3008, 0, 32'h300c, 1, 32'h3008, 1, 32'h3008, 32'h2401_3008, 0);

        // Two wait cycles: request held stable, stall ignored while nothing is valid.
        cyc(0, 32'hdead_0001, 0, 32'h1111_1111, 1, 32'h300c, 0, 0, 0, 0);
        cyc(0, 32'hdead_0002, 1, 32'h2222_2222, 1, 32'h300c, 0, 0, 0, 0);
        cyc(1, 32'h2401_300c, 0, 32'h3010,      1, 32'h300c, 1, 32'h300c, 32'h2401_300c, 0);
        check32("pc_after_wait", F_pc, 32'h3010);

        // Stall on ack cycle: instruction buffered, stray acks and npc ignored in hold.
        cyc(1, 32'h3c01_0001, 1, 32'h5555_5555, 1, 32'h3010, 1, 32'h3010, 32'h3c01_0001, 0);
        cyc(1, 32'hbad0_0001, 1, 32'h6666_6666, 0, 0,        1, 32'h3010, 32'h3c01_0001, 0);
        cyc(0, 32'hbad0_0002, 1, 32'h7777_7777, 0, 0,        1, 32'h3010, 32'h3c01_0001, 0);
        cyc(0, 32'hbad0_0003, 0, 32'h3002,      0, 0,        1, 32'h3010, 32'h3c01_0001, 0);
        check32("pc_after_hold", F_pc, 32'h3002);

        // Misaligned then below-range targets: zero-latency error delivery, no request.
        cyc(1, 32'hdead_beef, 0, 32'h0000_2ffc, 0, 0, 1, 32'h3002, 32'h0, 1);
        cyc(0, 32'h0,         1, 32'h0000_0000, 0, 0, 1, 32'h2ffc, 32'h0, 1);
        cyc(0, 32'h0,         0, 32'h0000_3400, 0, 0, 1, 32'h2ffc, 32'h0, 1);

        // Jump target, then ranges just above and at the upper bound.
        cyc(1, 32'h2401_3400, 0, 32'h0000_7000, 1, 32'h3400, 1, 32'h3400, 32'h2401_3400, 0);
        cyc(0, 32'h0,         0, 32'h0000_6ffc, 0, 0,        1, 32'h7000, 32'h0, 1);
        cyc(1, 32'h2401_6ffc, 0, 32'h0000_3020, 1, 32'h6ffc, 1, 32'h6ffc, 32'h2401_6ffc, 0);

        // Reset asserted mid-wait: request drops at once, refetch from PC_RESET.
        cyc(0, 32'h0, 0, 32'h0, 1, 32'h3020, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check32("midrst_req",   {31'd0, imem_req}, 32'd0);
        check32("midrst_pc",    F_pc,              32'h3000);
        check32("midrst_valid", {31'd0, F_valid},  32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(1, 32'h2401_3000, 0, 32'h3004, 1, 32'h3000, 1, 32'h3000, 32'h2401_3000, 0);
        cyc(0, 32'h0,         0, 32'h0,    1, 32'h3004, 0, 0, 0, 0);

        check32("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
